seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Downstream display stage for the Basys3 decoder labs. Latches a 4-digit hex value
//   and time-multiplexes it onto the on-board 4-digit common-anode 7-segment display.
//   Output is the same 11-bit bus consumed by the board constraints:
//   display_out = {an[3:0], seg[6:0]}. Both fields are active-low, and seg is ordered a..g
//   with a at the MSB.
// PARAMETERS
//   SCAN_DIV  100000  clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2
//   CNT_W     17      divider counter width; must satisfy 2**CNT_W >= SCAN_DIV
// PORTS
//   clk          in   1   system clock, 100 MHz
//   rst_n        in   1   asynchronous, active-low reset
//   load         in   1   one-cycle strobe; captures data_in and digit_en
//   data_in      in   16  hex digits; [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   digit_en     in   4   per-digit enable, captured on load; 0 = digit dark
//   lz_blank     in   1   leading-zero blanking enable (live, not latched)
//   digit_sel    out  2   index of the digit currently driven
//   display_out  out  11  {an[3:0], seg[6:0]}, active-low
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - display_out=11'h7FF (all dark), digit_sel=2'd3
//     - data_q=0, en_q=0, cnt=0
//     - Takes effect immediately, including mid-slot; the scan restarts on release.
//   Divider:
//     - cnt counts 0..SCAN_DIV-1 and wraps to 0.
//     - tick = (cnt==SCAN_DIV-1).
//   Tick edge:
//     - idx <= idx+1 mod 4 (3->0 wraps).
//     - display_out <= encode(idx+1) on the same edge; both outputs are registered and change together.
//     - First visible update is digit 0, SCAN_DIV cycles after reset release.
//     - display_out and digit_sel hold constant between ticks: no mid-slot glitches.
//   Load:
//     - On a clk edge with load=1: data_q<=data_in, en_q<=digit_en.
//     - New data is visible from the next tick edge onward, never mid-slot.
//     - If load and tick coincide, that tick's encode uses the OLD data_q/en_q.
//     - Back-to-back loads: the last one wins.
//   encode(k):
//     - an = ~(4'b0001<<k); digit 3 = an[3] = display_out[10].
//     - seg from nibble data_q[4k+3:4k], active-low a..g:
//       0=0000001  1=1001111  2=0010010  3=0000110  4=1001100  5=0100100
//       6=0100000  7=0001111  8=0000000  9=0000100  A=0001000  b=1100000
//       C=0110001  d=1000010  E=0110000  F=0111000
//   Dark digit: the whole word is 11'h7FF for that slot. A digit is dark when
//     - en_q[k]==0, or
//     - lz_blank==1, k!=0, and nibbles k..3 are all zero.
//     Digit 0 is never blanked by lz_blank. Dark slots still consume SCAN_DIV cycles,
//     keeping the duty cycle uniform at 1/4.
// TESTING (sim with SCAN_DIV=4)
//   1 rst_n=0 mid-slot -> display_out=11'h7FF, digit_sel=3 immediately; stays so until first tick after release
//   2 load 16'h1234, en=4'hF, lz=0 -> slots in order:
//       {1110,1001100}, {1101,0000110}, {1011,0010010}, {0111,1001111}, each 4 cycles, then repeat
//   3 load 16'h0050, lz=1 -> digit0 {1110,0000001}, digit1 {1101,0100100}, digits 2,3 = 11'h7FF;
//       load 16'h0000 -> only digit0 shows '0'
//   4 load 16'h8888, en=4'b0101 -> digits 0,2 show {..,0000000}; digits 1,3 = 11'h7FF
//   5 load 16'hAAAA asserted on a tick cycle after 16'h1234 -> that slot shows old nibble;
//       next slot shows 'A' (0001000)
//   6 run 64 cycles -> digit_sel sequence 0,1,2,3 with wrap; exactly one an bit low per enabled slot

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Latches a 4-digit hex value and time-multiplexes it onto a common-anode
// 7-segment display; output bus is {an[3:0], seg[6:0]}, both active-low.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [1:0]  digit_sel,
  output logic [10:0] display_out
);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [15:0]      data_q;
  logic [3:0]       en_q;
  logic [1:0]       nxt_idx;
  logic [3:0]       nib;
  logic             upper_zero;
  logic [6:0]       seg;
  logic             dark;
  logic [10:0]      word_nxt;

  assign tick    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign nxt_idx = digit_sel + 2'd1;

  // Encoding reads the pre-load data_q/en_q, so a load coinciding with a tick
  // only shows up on the following slot.
  always_comb begin
    nib        = '0;
    upper_zero = 1'b0;
    case (nxt_idx)
      2'd0: begin nib = data_q[3:0];   upper_zero = 1'b0;               end
      2'd1: begin nib = data_q[7:4];   upper_zero = ~|data_q[15:4];     end
      2'd2: begin nib = data_q[11:8];  upper_zero = ~|data_q[15:8];     end
      2'd3: begin nib = data_q[15:12]; upper_zero = ~|data_q[15:12];    end
      default: begin nib = '0; upper_zero = 1'b0; end
    endcase
  end

  always_comb begin
    seg = '1;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = '1;
    endcase
  end

  always_comb begin
    dark     = ~en_q[nxt_idx] | (lz_blank & upper_zero);
    word_nxt = dark ? '1 : {~(4'b0001 << nxt_idx), seg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      en_q   <= '0;
    end else if (load) begin
      data_q <= data_in;
      en_q   <= digit_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel   <= 2'd3;
      display_out <= '1;
    end else if (tick) begin
      digit_sel   <= nxt_idx;
      display_out <= word_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected slot words are queued when
// loads are driven and popped as each new scan slot appears.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV   = 4;
  localparam int CNT_W      = 3;
  localparam int MODE_NONE  = 0;
  localparam int MODE_EARLY = 1;
  localparam int MODE_TICK  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic [1:0]  digit_sel;
  logic [10:0] display_out;

  int checks = 0;
  int passes = 0;

  logic [12:0] sb[$];
  logic [10:0] cur[4];
  logic [1:0]  pred_sel;
  logic [1:0]  last_sel;

  logic [1:0]  s;
  logic [10:0] w;
  bit          held;
  bit          ok;
  logic [12:0] exp_v;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .digit_sel  (digit_sel),
    .display_out(display_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] word(input logic [1:0] k, input logic [6:0] sg);
    word = {~(4'b0001 << k), sg};
  endfunction

  function automatic logic [12:0] pop_exp();
    if (sb.size() > 0) pop_exp = sb.pop_front();
    else pop_exp = 'x;
  endfunction

  task automatic push_slots(input int n);
    for (int i = 0; i < n; i++) begin
      pred_sel = pred_sel + 2'd1;
      sb.push_back({pred_sel, cur[pred_sel]});
    end
  endtask

  // Waits (bounded) for the next slot, samples it, watches it hold for the
  // rest of the slot, and optionally drives a load early or on the closing tick.
  task automatic capture_slot(input int mode, input logic [15:0] d, input logic [3:0] e,
                              input logic lz, output logic [1:0] so, output logic [10:0] wo,
                              output bit held_o, output bit ok_o);
    int n = 0;
    ok_o = 1'b1;
    held_o = 1'b1;
    while (digit_sel === last_sel) begin
      if (n >= 3 * SCAN_DIV) begin
        ok_o = 1'b0;
        break;
      end
      @(negedge clk);
      n++;
    end
    so = digit_sel;
    wo = display_out;
    last_sel = digit_sel;
    for (int i = 0; i < SCAN_DIV; i++) begin
      if (i > 0 && (display_out !== wo || digit_sel !== so)) held_o = 1'b0;
      load = (mode == MODE_EARLY && i == 0) || (mode == MODE_TICK && i == SCAN_DIV - 1);
      if (load) begin
        data_in  = d;
        digit_en = e;
        lz_blank = lz;
      end
      if (i < SCAN_DIV - 1) @(negedge clk);
    end
    if (load) begin
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic test_reset;
    bit hold_ok;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (display_out !== 11'h7FF || digit_sel !== 2'd3)
      $display("FAIL reset_init: got sel=%0d word=%h, expected sel=3 word=7ff", digit_sel, display_out);
    else passes++;
    rst_n = 1'b1;
    load = 1'b1; data_in = 16'h1234; digit_en = 4'hF;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (digit_sel !== 2'd0 || display_out !== word(2'd0, 7'b1001100))
      $display("FAIL pre_reset_slot: got sel=%0d word=%b, expected sel=0 word=%b",
               digit_sel, display_out, word(2'd0, 7'b1001100));
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (display_out !== 11'h7FF || digit_sel !== 2'd3)
      $display("FAIL reset_midslot: got sel=%0d word=%h, expected sel=3 word=7ff", digit_sel, display_out);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < SCAN_DIV - 1; i++) begin
      @(negedge clk);
      if (display_out !== 11'h7FF || digit_sel !== 2'd3) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok)
      $display("FAIL reset_hold: got an early change, expected sel=3 word=7ff until first tick");
    else passes++;
    @(negedge clk);
    checks++;
    if (display_out !== 11'h7FF || digit_sel !== 2'd0)
      $display("FAIL first_tick: got sel=%0d word=%h, expected sel=0 word=7ff", digit_sel, display_out);
    else passes++;
    last_sel = 2'd0;
    pred_sel = 2'd0;
    for (int k = 0; k < 4; k++) cur[k] = 11'h7FF;
  endtask

  task automatic test_basic;
    push_slots(1);
    cur[0] = word(2'd0, 7'b1001100);
    cur[1] = word(2'd1, 7'b0000110);
    cur[2] = word(2'd2, 7'b0010010);
    cur[3] = word(2'd3, 7'b1001111);
    push_slots(7);
    for (int i = 0; i < 8; i++) begin
      capture_slot((i == 0) ? MODE_EARLY : MODE_NONE, 16'h1234, 4'hF, 1'b0, s, w, held, ok);
      exp_v = pop_exp();
      checks++;
      if ({s, w} !== exp_v || !held || !ok)
        $display("FAIL basic_slot%0d: got sel=%0d word=%b held=%0b ok=%0b, expected sel=%0d word=%b",
                 i, s, w, held, ok, exp_v[12:11], exp_v[10:0]);
      else passes++;
    end
  endtask

  task automatic test_lz_blank;
    push_slots(1);
    cur[0] = word(2'd0, 7'b0000001);
    cur[1] = word(2'd1, 7'b0100100);
    cur[2] = 11'h7FF;
    cur[3] = 11'h7FF;
    push_slots(4);
    for (int i = 0; i < 5; i++) begin
      capture_slot((i == 0) ? MODE_EARLY : MODE_NONE, 16'h0050, 4'hF, 1'b1, s, w, held, ok);
      exp_v = pop_exp();
      checks++;
      if ({s, w} !== exp_v || !held || !ok)
        $display("FAIL lz_0050_slot%0d: got sel=%0d word=%b held=%0b ok=%0b, expected sel=%0d word=%b",
                 i, s, w, held, ok, exp_v[12:11], exp_v[10:0]);
      else passes++;
    end
    push_slots(1);
    cur[1] = 11'h7FF;
    push_slots(4);
    for (int i = 0; i < 5; i++) begin
      capture_slot((i == 0) ? MODE_EARLY : MODE_NONE, 16'h0000, 4'hF, 1'b1, s, w, held, ok);
      exp_v = pop_exp();
      checks++;
      if ({s, w} !== exp_v || !held || !ok)
        $display("FAIL lz_0000_slot%0d: got sel=%0d word=%b held=%0b ok=%0b, expected sel=%0d word=%b",
                 i, s, w, held, ok, exp_v[12:11], exp_v[10:0]);
      else passes++;
    end
  endtask

  task automatic test_digit_enable;
    push_slots(1);
    cur[0] = word(2'd0, 7'b0000000);
    cur[1] = 11'h7FF;
    cur[2] = word(2'd2, 7'b0000000);
    cur[3] = 11'h7FF;
    push_slots(4);
    for (int i = 0; i < 5; i++) begin
      capture_slot((i == 0) ? MODE_EARLY : MODE_NONE, 16'h8888, 4'b0101, 1'b1, s, w, held, ok);
      exp_v = pop_exp();
      checks++;
      if ({s, w} !== exp_v || !held || !ok)
        $display("FAIL enable_slot%0d: got sel=%0d word=%b held=%0b ok=%0b, expected sel=%0d word=%b",
                 i, s, w, held, ok, exp_v[12:11], exp_v[10:0]);
      else passes++;
    end
  endtask

  task automatic test_load_on_tick;
    push_slots(1);
    cur[0] = word(2'd0, 7'b1001100);
    cur[1] = word(2'd1, 7'b0000110);
    cur[2] = word(2'd2, 7'b0010010);
    cur[3] = word(2'd3, 7'b1001111);
    push_slots(2);
    for (int k = 0; k < 4; k++) cur[k] = word(2'(k), 7'b0001000);
    push_slots(2);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) capture_slot(MODE_EARLY, 16'h1234, 4'hF, 1'b0, s, w, held, ok);
      else if (i == 1) capture_slot(MODE_TICK, 16'hAAAA, 4'hF, 1'b0, s, w, held, ok);
      else capture_slot(MODE_NONE, 16'h0, 4'h0, 1'b0, s, w, held, ok);
      exp_v = pop_exp();
      checks++;
      if ({s, w} !== exp_v || !held || !ok)
        $display("FAIL tick_load_slot%0d: got sel=%0d word=%b held=%0b ok=%0b, expected sel=%0d word=%b",
                 i, s, w, held, ok, exp_v[12:11], exp_v[10:0]);
      else passes++;
    end
  endtask

  task automatic test_scan;
    bit onehot_ok = 1'b1;
    push_slots(1);
    cur[0] = word(2'd0, 7'b1001100);
    cur[1] = word(2'd1, 7'b0000110);
    cur[2] = 11'h7FF;
    cur[3] = word(2'd3, 7'b1001111);
    push_slots(16);
    for (int i = 0; i < 17; i++) begin
      capture_slot((i == 0) ? MODE_EARLY : MODE_NONE, 16'h1234, 4'b1011, 1'b0, s, w, held, ok);
      exp_v = pop_exp();
      checks++;
      if ({s, w} !== exp_v || !held || !ok)
        $display("FAIL scan_slot%0d: got sel=%0d word=%b held=%0b ok=%0b, expected sel=%0d word=%b",
                 i, s, w, held, ok, exp_v[12:11], exp_v[10:0]);
      else passes++;
      if (i > 0 && s !== 2'd2 && ($countones(~w[10:7]) != 1 || w[10:7] !== ~(4'b0001 << s)))
        onehot_ok = 1'b0;
    end
    checks++;
    if (!onehot_ok)
      $display("FAIL scan_onehot_an: got an enabled slot without exactly one low an bit, expected one-hot-low an matching digit_sel");
    else passes++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_lz_blank;
    test_digit_enable;
    test_load_on_tick;
    test_scan;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
